// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer driving ALU op, operand muxes, register strobes and memory handshake.
// Optional MU0_ILLEGAL_TRAP_EN: opcodes 8-15 halt with a sticky illegal flag instead of acting as NOPs.
module mu0_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ir_op,
    input  logic             acc_z,
    input  logic             acc_n,
    input  logic             mem_ack,
    output logic [3:0]       alu_op,
    output logic             a_sel,
    output logic             b_sel,
    output logic             addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_ld,
    output logic             pc_ld,
    output logic             acc_ld,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] ALU_ZERO  = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_A_INC = 4'd3;
    localparam logic [3:0] ALU_B     = 4'd4;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               done;
    logic               jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        alu_op   = ALU_ZERO;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        addr_sel = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_ld    = 1'b0;
        pc_ld    = 1'b0;
        acc_ld   = 1'b0;
        halted   = 1'b0;
        done     = 1'b0;
        jump     = 1'b0;
        case (state_q)
            S_INIT: begin
                alu_op  = ALU_ZERO;
                pc_ld   = 1'b1;
                acc_ld  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_ld   = 1'b1;
                    a_sel   = 1'b1;
                    alu_op  = ALU_A_INC;
                    pc_ld   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ir_op)
                    OP_LDA: begin
                        mem_req  = 1'b1;
                        addr_sel = 1'b1;
                        if (mem_ack) begin
                            alu_op = ALU_B;
                            acc_ld = 1'b1;
                            done   = 1'b1;
                        end
                    end
                    OP_STO: begin
                        mem_req  = 1'b1;
                        mem_we   = 1'b1;
                        addr_sel = 1'b1;
                        done     = mem_ack;
                    end
                    OP_ADD, OP_SUB: begin
                        mem_req  = 1'b1;
                        addr_sel = 1'b1;
                        if (mem_ack) begin
                            alu_op = (ir_op == OP_ADD) ? ALU_ADD : ALU_SUB;
                            acc_ld = 1'b1;
                            done   = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        jump = 1'b1;
                        done = 1'b1;
                    end
                    OP_JGE: begin
                        jump = ~acc_n;
                        done = 1'b1;
                    end
                    OP_JNE: begin
                        jump = ~acc_z;
                        done = 1'b1;
                    end
                    OP_STP: state_d = S_HALT;
                    default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        done = 1'b1;
`endif
                    end
                endcase
                if (jump) begin
                    b_sel  = 1'b1;
                    alu_op = ALU_B;
                    pc_ld  = 1'b1;
                end
                if (done) state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    // Every EXEC->FETCH transition retires exactly one instruction; STP and traps never reach it.
    assign retired_d = done ? retired_q + CNT_W'(1) : retired_q;
    assign retired   = retired_q;

`ifdef MU0_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_EXEC && ir_op[3]) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: directed vector table, hand-written corner sequences, and randomized
// instruction streams whose expected per-cycle outputs are built from the instruction-level rules.
module tb_mu0_control;

`ifdef MU0_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ir_op = '0;
    logic        acc_z = 1'b0, acc_n = 1'b0, mem_ack = 1'b0;
    logic [3:0]  alu_op;
    logic        a_sel, b_sel, addr_sel, mem_req, mem_we, ir_ld, pc_ld, acc_ld, halted, illegal;
    logic [15:0] retired;

    mu0_control #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .acc_z(acc_z), .acc_n(acc_n), .mem_ack(mem_ack),
        .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel), .addr_sel(addr_sel), .mem_req(mem_req),
        .mem_we(mem_we), .ir_ld(ir_ld), .pc_ld(pc_ld), .acc_ld(acc_ld), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          exp_ret = 0;
    logic        exp_il = 1'b0;

    // {alu_op, a_sel, b_sel, addr_sel, mem_req, mem_we, ir_ld, pc_ld, acc_ld, halted, illegal}
    function automatic logic [13:0] mk(input int alu, input bit a, input bit b, input bit as,
                                       input bit rq, input bit we, input bit ir, input bit pc,
                                       input bit acc);
        logic [3:0] op4;
        op4 = 4'(alu);
        return {op4, a, b, as, rq, we, ir, pc, acc, 1'b0, 1'b0};
    endfunction

    function automatic logic [13:0] halt_vec();
        return {12'b0, 1'b1, exp_il};
    endfunction

    // Inputs are applied just after a rising edge, outputs sampled at the falling edge.
    task automatic step(input bit ack, input logic [3:0] op, input bit z, input bit n,
                        input logic [13:0] exp_o, input string nm);
        logic [13:0] got;
        mem_ack = ack; ir_op = op; acc_z = z; acc_n = n;
        @(negedge clk);
        got = {alu_op, a_sel, b_sel, addr_sel, mem_req, mem_we, ir_ld, pc_ld, acc_ld, halted, illegal};
        n_vec++;
        if (got !== exp_o || retired !== 16'(exp_ret)) begin
            n_bad++;
            $display("FAIL %s: outputs=%h retired=%0d, required outputs=%h retired=%0d",
                     nm, got, retired, exp_o, exp_ret);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ack = 1'b0;
        exp_ret = 0; exp_il = 1'b0;
        #2;
        n_vec++;
        if (mem_req !== 1'b0 || retired !== 16'd0 || halted !== 1'b0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: req=%b ret=%0d halted=%b illegal=%b, required 0 0 0 0",
                     mem_req, retired, halted, illegal);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'($urandom), 4'($urandom), 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "init");
    endtask

    task automatic do_fetch(input int w);
        for (int i = 0; i < w; i++)
            step(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "fetch_wait");
        step(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), mk(3, 1, 0, 0, 1, 0, 1, 1, 0), "fetch_ack");
    endtask

    // Returns 1 when the instruction halts the machine.
    task automatic do_exec(input logic [3:0] op, input int w, input bit z, input bit n, output bit stop);
        bit tk;
        stop = 1'b0;
        if (op <= 4'd3) begin
            for (int i = 0; i < w; i++)
                step(1'b0, op, z, n, mk(0, 0, 0, 1, 1, op == 4'd1, 0, 0, 0), "mem_wait");
            case (op)
                4'd0:    step(1'b1, op, z, n, mk(4, 0, 0, 1, 1, 0, 0, 0, 1), "lda_ack");
                4'd1:    step(1'b1, op, z, n, mk(0, 0, 0, 1, 1, 1, 0, 0, 0), "sto_ack");
                default: step(1'b1, op, z, n, mk(op - 4'd1, 0, 0, 1, 1, 0, 0, 0, 1), "alu_ack");
            endcase
            exp_ret++;
        end else if (op <= 4'd6) begin
            tk = (op == 4'd4) || (op == 4'd5 && !n) || (op == 4'd6 && !z);
            step(1'($urandom), op, z, n, tk ? mk(4, 0, 1, 0, 0, 0, 0, 1, 0) : mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "jump");
            exp_ret++;
        end else begin
            step(1'($urandom), op, z, n, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), op == 4'd7 ? "stp" : "illegal_op");
            if (op == 4'd7 || TRAP) begin
                stop = 1'b1;
                if (op != 4'd7) exp_il = 1'b1;
            end else begin
                exp_ret++;
            end
        end
    endtask

    task automatic check_halt(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), halt_vec(), "halt");
    endtask

    typedef struct {
        bit          ack;
        logic [3:0]  op;
        bit          z;
        bit          n;
        logic [13:0] exp_o;
        int          ret;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit ack, input logic [3:0] op, input bit z, input bit n,
                                input logic [13:0] e, input int ret);
        vec_t v;
        v.ack = ack; v.op = op; v.z = z; v.n = n; v.exp_o = e; v.ret = ret;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [13:0] F_W, F_A, ZZ;
        bit          stop;
        F_W = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        F_A = mk(3, 1, 0, 0, 1, 0, 1, 1, 0);
        ZZ  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed program, starting right after reset release.
        add(1, 4'h0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 0);      // INIT, stray ack ignored
        add(0, 4'h9, 0, 0, F_W, 0); add(0, 4'h9, 0, 0, F_W, 0); add(0, 4'h9, 0, 0, F_W, 0);
        add(1, 4'h9, 0, 0, F_A, 0);
        add(1, 4'h2, 0, 0, mk(1, 0, 0, 1, 1, 0, 0, 0, 1), 0);      // ADD zero-wait
        add(1, 4'h0, 0, 0, F_A, 1);
        add(1, 4'h5, 0, 1, ZZ, 1);                                 // JGE not taken
        add(1, 4'h0, 0, 0, F_A, 2);
        add(0, 4'h6, 0, 1, mk(4, 0, 1, 0, 0, 0, 0, 1, 0), 2);      // JNE taken
        add(1, 4'h0, 0, 0, F_A, 3);
        add(0, 4'h1, 0, 0, mk(0, 0, 0, 1, 1, 1, 0, 0, 0), 3);
        add(0, 4'h1, 0, 0, mk(0, 0, 0, 1, 1, 1, 0, 0, 0), 3);
        add(1, 4'h1, 0, 0, mk(0, 0, 0, 1, 1, 1, 0, 0, 0), 3);      // STO ack, no acc_ld
        add(1, 4'h0, 0, 0, F_A, 4);
        add(1, 4'h4, 1, 1, mk(4, 0, 1, 0, 0, 0, 0, 1, 0), 4);      // JMP ignores ack
        add(1, 4'h0, 0, 0, F_A, 5);
        add(1, 4'h0, 0, 0, mk(4, 0, 0, 1, 1, 0, 0, 0, 1), 5);      // LDA
        add(1, 4'h0, 0, 0, F_A, 6);
        add(0, 4'h3, 0, 0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0), 6);
        add(1, 4'h3, 0, 0, mk(2, 0, 0, 1, 1, 0, 0, 0, 1), 6);      // SUB after 1 wait
        add(1, 4'h0, 0, 0, F_A, 7);
        add(1, 4'h7, 0, 0, ZZ, 7);                                 // STP
        add(1, 4'h3, 0, 0, {12'b0, 2'b10}, 7);
        add(0, 4'h0, 1, 1, {12'b0, 2'b10}, 7);
        add(1, 4'h1, 0, 0, {12'b0, 2'b10}, 7);

        repeat (2) @(posedge clk); #1;
        do_reset();
        n_vec--;  // the INIT step is re-checked from the table below
        rst_n = 1'b0; #1; rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        foreach (tbl[i]) begin
            exp_ret = tbl[i].ret;
            step(tbl[i].ack, tbl[i].op, tbl[i].z, tbl[i].n, tbl[i].exp_o, $sformatf("tbl[%0d]", i));
        end

        // Reset asserted mid-request drops mem_req immediately, then restart from INIT.
        do_reset();
        step(1'b0, 4'h0, 0, 0, F_W, "fetch_wait");
        rst_n = 1'b0; #1;
        n_vec++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_req: mem_req=%b, required 0", mem_req);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; exp_ret = 0; exp_il = 1'b0;
        step(1'b0, 4'h0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "init_after_mid_reset");
        do_fetch(0);

        // Opcode 0xF: trap halts in one build, NOP in the other.
        do_exec(4'hF, 0, 0, 0, stop);
        if (TRAP) begin
            check_halt(3);
        end else begin
            do_fetch(1);
            do_exec(4'h4, 0, 0, 0, stop);
            do_fetch(0);
        end

        // Randomized instruction streams.
        for (int r = 0; r < 40; r++) begin
            do_reset();
            stop = 1'b0;
            for (int k = 0; k < 25 && !stop; k++) begin
                logic [3:0] op;
                op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
                do_fetch($urandom_range(0, 3));
                do_exec(op, $urandom_range(0, 3), 1'($urandom), 1'($urandom), stop);
            end
            if (stop) check_halt(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
